// File: rtl/mem_word_master.sv
// mem_word_master: splits one 32-bit word load/store into four byte
// accesses on the 8-bit exmemory port and assembles load bytes into rdata.
// Ports: clk, reset (async, active high); req/we/addr/wdata request side;
// busy/done/rdata status and load result; adr/memwrite/writedata/memdata
// byte bus to exmemory.
// Optional: `define MEM_WORD_MASTER_BYTE_MASK_EN adds be[3:0] lane enables.
module mem_word_master #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [31:0]      wdata,
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
    input  logic [3:0]       be,
`endif
    output logic             busy,
    output logic             done,
    output logic [31:0]      rdata,
    output logic [WIDTH-1:0] adr,
    output logic             memwrite,
    output logic [7:0]       writedata,
    input  logic [7:0]       memdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       cnt_nx;
    logic [WIDTH-3:0] base_q, base_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] adr_q, adr_d;
    logic             mw_q, mw_d;
    logic [7:0]       wd_q, wd_d;
    logic [3:0]       be_acc;
    logic [3:0]       be_cur;
    logic             unused_addr_lsb;

    // Word aligned: the two low address bits are deliberately dropped.
    assign unused_addr_lsb = ^addr[1:0];

`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
    logic [3:0] be_q, be_d;
    assign be_acc = be;
    assign be_cur = be_q;
`else
    assign be_acc = 4'hF;
    assign be_cur = 4'hF;
`endif

    assign cnt_nx = cnt_q + 2'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
        be_d    = be_q;
`endif
        // Bus outputs are registered and idle at zero unless set below.
        busy_d  = 1'b0;
        done_d  = 1'b0;
        adr_d   = '0;
        mw_d    = 1'b0;
        wd_d    = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = XFER;
                    cnt_d   = 2'd0;
                    base_d  = addr[WIDTH-1:2];
                    we_d    = we;
                    wdata_d = wdata;
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
                    be_d    = be;
`endif
                    // Present lane 0 in the first byte cycle.
                    busy_d  = 1'b1;
                    adr_d   = {addr[WIDTH-1:2], 2'b00};
                    mw_d    = we & be_acc[0];
                    wd_d    = we ? wdata[7:0] : 8'h00;
                end
            end
            XFER: begin
                if (!we_q) begin
                    rdata_d[{cnt_q, 3'b000} +: 8] =
                        be_cur[cnt_q] ? memdata : 8'h00;
                end
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                    cnt_d   = 2'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_nx;
                    busy_d = 1'b1;
                    adr_d  = {base_q, cnt_nx};
                    mw_d   = we_q & be_cur[cnt_nx];
                    wd_d   = we_q ? wdata_q[{cnt_nx, 3'b000} +: 8]
                                  : 8'h00;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            base_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            adr_q   <= '0;
            mw_q    <= 1'b0;
            wd_q    <= 8'h00;
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
            be_q    <= 4'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            adr_q   <= adr_d;
            mw_q    <= mw_d;
            wd_q    <= wd_d;
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
            be_q    <= be_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign adr       = adr_q;
    assign memwrite  = mw_q;
    assign writedata = wd_q;

endmodule

// File: tb/tb_mem_word_master.sv
// tb_mem_word_master: directed bench for mem_word_master with a
// 256-byte exmemory model (combinational read, clocked write).
module tb_mem_word_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [7:0]  adr;
    logic        memwrite;
    logic [7:0]  writedata;
    logic [7:0]  memdata;
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
    logic [3:0]  be;
`endif

    logic [7:0]  mem [256];
    logic        mem_init;

    int checks = 0;
    int failures = 0;
    int ndone = 0;
    int nd0;

    always #5 clk = ~clk;

    mem_word_master #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
        .be        (be),
`endif
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .adr       (adr),
        .memwrite  (memwrite),
        .writedata (writedata),
        .memdata   (memdata)
    );

    assign memdata = mem[adr];

    // Initial contents: mem[i] = i ^ 0xA5.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (memwrite) begin
            mem[adr] <= writedata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) ndone++;
    endtask

    // Issue one request, then check the four byte cycles and done cycle.
    task automatic run_xfer(input logic w, input logic [7:0] a,
                            input logic [31:0] wd,
                            input logic [3:0] mw_exp);
        req = 1'b1; we = w; addr = a; wdata = wd;
        tick();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy_c%0d", i + 1), {31'b0, busy}, 32'd1);
            chk($sformatf("mw_c%0d", i + 1), {31'b0, memwrite},
                {31'b0, mw_exp[i]});
            chk($sformatf("adr_c%0d", i + 1), {24'b0, adr},
                {24'b0, a[7:2], 2'(i)});
            chk($sformatf("wd_c%0d", i + 1), {24'b0, writedata},
                w ? {24'b0, wd[8*i +: 8]} : 32'd0);
            tick();
        end
        chk("done_c5", {31'b0, done}, 32'd1);
        chk("busy_c5", {31'b0, busy}, 32'd0);
        chk("adr_c5", {24'b0, adr}, 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 32'h0;
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
        be = 4'hF;
`endif
        tick();
        mem_init = 1'b0;
        // 1: reset state and quiet idle
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_mw", {31'b0, memwrite}, 32'd0);
        chk("rst_adr", {24'b0, adr}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        tick(); tick();
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_mw", {31'b0, memwrite}, 32'd0);
        chk("idle_done_cnt", ndone, 32'd0);

        // 2: store DEADBEEF at 0x10
        run_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'b1111);
        chk("m10", {24'b0, mem[8'h10]}, 32'hEF);
        chk("m11", {24'b0, mem[8'h11]}, 32'hBE);
        chk("m12", {24'b0, mem[8'h12]}, 32'hAD);
        chk("m13", {24'b0, mem[8'h13]}, 32'hDE);
        chk("st_rdata_untouched", rdata, 32'd0);

        // 3: load from 0x13 -> word at 0x10
        run_xfer(1'b0, 8'h13, 32'h0, 4'b0000);
        chk("ld_rdata", rdata, 32'hDEADBEEF);

        // 4: top word store/load
        run_xfer(1'b1, 8'hFC, 32'h01020304, 4'b1111);
        chk("m00_untouched", {24'b0, mem[8'h00]}, 32'hA5);
        chk("mFF", {24'b0, mem[8'hFF]}, 32'h01);
        chk("st_rdata_hold", rdata, 32'hDEADBEEF);
        run_xfer(1'b0, 8'hFC, 32'h0, 4'b0000);
        chk("ld_top", rdata, 32'h01020304);

        // 5: req held high, addr changed mid-transfer, mid-XFER pulse
        nd0 = ndone;
        req = 1'b1; we = 1'b0; addr = 8'h10;
        tick();
        chk("b2b_c1_adr", {24'b0, adr}, 32'h10);
        addr = 8'hFC;
        tick(); tick(); tick();
        chk("b2b_c4_adr", {24'b0, adr}, 32'h13);
        tick();
        chk("b2b_c5_done", {31'b0, done}, 32'd1);
        chk("b2b_c5_rdata", rdata, 32'hDEADBEEF);
        tick();
        chk("b2b_c6_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("b2b_c7_busy", {31'b0, busy}, 32'd1);
        chk("b2b_c7_adr", {24'b0, adr}, 32'hFC);
        req = 1'b0;
        tick();
        req = 1'b1; addr = 8'h40;
        tick();
        req = 1'b0;
        chk("b2b_c9_adr", {24'b0, adr}, 32'hFE);
        tick(); tick();
        chk("b2b_c11_done", {31'b0, done}, 32'd1);
        tick(); tick();
        chk("b2b_c13_busy", {31'b0, busy}, 32'd0);
        chk("b2b_done_cnt", ndone - nd0, 32'd2);
        chk("b2b_rdata", rdata, 32'h01020304);

        // 6: reset in byte cycle 3 of a store
        nd0 = ndone;
        req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 32'hAABBCCDD;
        tick();
        req = 1'b0;
        tick(); tick();
        chk("rstmid_mw_pre", {31'b0, memwrite}, 32'd1);
        chk("rstmid_adr_pre", {24'b0, adr}, 32'h22);
        reset = 1'b1;
        #1;
        chk("rstmid_mw", {31'b0, memwrite}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("rstmid_no_done", ndone - nd0, 32'd0);
        chk("m20", {24'b0, mem[8'h20]}, 32'hDD);
        chk("m21", {24'b0, mem[8'h21]}, 32'hCC);
        chk("m22", {24'b0, mem[8'h22]}, 32'h87);
        chk("m23", {24'b0, mem[8'h23]}, 32'h86);

`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
        // 7: byte-masked store and loads
        be = 4'b0101;
        run_xfer(1'b1, 8'h30, 32'h11223344, 4'b0101);
        be = 4'b1111;
        run_xfer(1'b0, 8'h30, 32'h0, 4'b0000);
        chk("mask_ld_all", rdata, 32'h96229444);
        be = 4'b0101;
        run_xfer(1'b0, 8'h30, 32'h0, 4'b0000);
        chk("mask_ld_0101", rdata, 32'h00220044);
        be = 4'b0000;
        run_xfer(1'b1, 8'h30, 32'hFFFFFFFF, 4'b0000);
        chk("mask_none_m30", {24'b0, mem[8'h30]}, 32'h44);
        be = 4'b1111;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
